// File: rtl/bit_stream_deser.sv
// rtl/bit_stream_deser.sv - serial bit stream to word deserializer with FIFO and valid/ready output
// Optional: define BIT_STREAM_DESER_MSB_FIRST_EN for MSB-first word assembly.
module bit_stream_deser #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_en,
  input  logic                       sync,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int CW = $clog2(WORD_W);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W-1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_shift;
  logic [CW-1:0]       r_cnt;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [LW-1:0]       r_level;
  logic                r_ovf;

  logic [WORD_W-1:0]   w_base;
  logic [WORD_W-1:0]   w_shift_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_wr_ok;
  logic                w_drop;

  // A sync discards the partial word, so the new bit shifts into a cleared register.
  assign w_base = sync ? '0 : r_shift;
`ifdef BIT_STREAM_DESER_MSB_FIRST_EN
  assign w_shift_nxt = {w_base[WORD_W-2:0], bit_in};
`else
  assign w_shift_nxt = {bit_in, w_base[WORD_W-1:1]};
`endif

  assign w_push  = bit_en && !sync && (r_state == COLLECT) && (r_cnt == LAST_BIT);
  assign w_pop   = out_valid && out_ready;
  assign w_full  = (r_level == FULL_LVL);
  assign w_wr_ok = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign out_valid = (r_level != '0);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign level     = r_level;
  assign overflow  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (sync) begin
      r_state <= COLLECT;
      r_shift <= bit_en ? w_shift_nxt : '0;
      r_cnt   <= bit_en ? CW'(1) : '0;
    end else if ((r_state == COLLECT) && bit_en) begin
      r_shift <= w_shift_nxt;
      r_cnt   <= (r_cnt == LAST_BIT) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr] <= w_shift_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr <= r_wr + PW'(1);
      if (w_pop)   r_rd <= r_rd + PW'(1);
      if (w_wr_ok && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_wr_ok) r_level <= r_level - LW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

endmodule

// File: doc/bit_stream_deser.md
Name: bit_stream_deser

Overview:
- Downstream consumer for the generated single-bit-output device (clk, rst, 1-bit output per cycle).
- Samples that serial bit stream, assembles WORD_W-bit words and buffers them in a DEPTH-entry FIFO.
- Presents buffered words on a valid/ready output port, which decouples the bit-per-cycle device from word-oriented logic or the testbench.

Parameters:
- WORD_W, 8: bits per assembled word (>=2).
- DEPTH, 4: FIFO entries (power of two, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial data bit from upstream __out0.
- bit_en  in  1  sample bit_in this cycle.
- sync  in  1  word-alignment restart pulse.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  WORD_W  FIFO head word.
- level  out  $clog2(DEPTH+1)  number of words in the FIFO.
- overflow  out  1  sticky: a completed word was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - out_valid=0, out_data=0, level=0, overflow=0.
  - Shift register=0, bit counter=0, FSM=HUNT.
  - FIFO pointers=0. Any partial word is lost.
- FSM states:
  - HUNT: bit_en is ignored until the first sync. On sync=1, go to COLLECT; if bit_en=1 in the same cycle, that bit is accepted as bit 0.
  - COLLECT: each cycle with bit_en=1 shifts bit_in in and increments the counter (0..WORD_W-1).
- Bit order: the first accepted bit lands in out_data[0] (LSB-first). The shift register shifts right, with the new bit entering at the MSB, so after WORD_W bits the first bit sits at [0].
- Word completion:
  - On the cycle the WORD_W-th bit is accepted, the assembled word (including that bit) is pushed into the FIFO.
  - The counter wraps to 0 and the FSM stays in COLLECT.
- Latency: the word becomes visible on out_data, with out_valid=1, on the cycle after the completing bit when the FIFO was empty. out_data is registered or read from FIFO storage; there is no combinational path from bit_in.
- sync in COLLECT:
  - The partial word is discarded and the counter is reset.
  - If bit_en=1 in the same cycle, that bit becomes bit 0 of the new word.
  - If sync coincides with a completing bit, sync wins: no push occurs.
- Output handshake:
  - Pop when out_valid && out_ready.
  - out_data and out_valid are stable while out_valid=1 && out_ready=0.
  - out_ready while out_valid=0 has no effect.
- FIFO full (level==DEPTH):
  - A push with no pop in the same cycle drops the word; overflow is set the next cycle and the FIFO is unchanged.
  - A push with a pop in the same cycle is accepted; level stays at DEPTH.
- Empty: push and pop in the same cycle cannot occur, because out_valid is 0 until the cycle after a push.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Pointers: $clog2(DEPTH) bits each, wrapping modulo DEPTH.
- overflow:
  - Set on a drop; cleared by clr_ovf.
  - If a drop coincides with clr_ovf, the set wins.

Optional Feature:
- Macro: BIT_STREAM_DESER_MSB_FIRST_EN.
- Defined: the first accepted bit lands in out_data[WORD_W-1] (shift left, new bit at LSB). All timing is unchanged.
- Undefined: LSB-first ordering as described in Behaviour.

Test Plan:
- Reset then sync, then bit_en=1 with bits 1,0,1,1,0,0,1,0 -> out_valid=1 one cycle after the 8th bit, out_data=0x4D, level=1. With the MSB_FIRST macro defined, out_data=0xB2.
- Bits streamed before any sync -> level stays 0 and out_valid stays 0. Assert sync with bit_en=1, bit_in=1, then 7 zero bits -> out_data=0x01.
- Hold out_ready=0 and stream 5 words 0x01..0x05 -> level=4 and overflow=1 after the 5th word; pops return 0x01,0x02,0x03,0x04. Pulse clr_ovf -> overflow=0.
- FIFO full with out_ready=1 on the cycle the 5th word completes -> no overflow, level stays 4; head sequence is 0x02..0x05.
- After 3 bits, pulse sync with bit_en=1, then complete 7 more bits giving value 0xA5 -> a single word 0xA5 is output; the 3-bit fragment is never output.
- Assert rst mid-word with level=2 -> out_valid drops immediately (asynchronously), level=0, FSM=HUNT. After release, a full sync and 8 bits produce exactly one new word.
